// File: rtl/spi_ram_ctrl.sv
// spi_ram_ctrl: turns 10-bit SPI command words into single-port RAM accesses.
// It owns the write/read address pointers and returns read bytes to the SPI slave.
module spi_ram_ctrl #(
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned ADDR_SIZE  = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned TX_HOLD    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           rx_data,
    input  logic                 rx_valid,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ack,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata,
    output logic                 busy,
    output logic                 err
);

    localparam int unsigned LAT_W  = 2;
    localparam int unsigned HOLD_W = $clog2(TX_HOLD + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        TX_WAIT  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_valid_q;
    logic [ADDR_SIZE-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0]  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_vld_q, wr_ptr_vld_d;
    logic                  rd_ptr_vld_q, rd_ptr_vld_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_SIZE-1:0]  ram_addr_q, ram_addr_d;
    logic [7:0]            ram_wdata_q, ram_wdata_d;
    logic                  busy_q;
    logic                  err_q, err_d;

    logic                  accept_c;
    logic                  take_cmd_c;
    logic [1:0]            cmd_c;
    logic [7:0]            payload_c;
    logic                  payload_ok_c;

    // Pointer advance with wrap at the last RAM word.
    function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
        return (p == ADDR_SIZE'(MEM_DEPTH - 1)) ? '0 : p + ADDR_SIZE'(1);
    endfunction

    // Command decode of the current SPI word; only rising edges of rx_valid count.
    assign accept_c     = rx_valid & ~rx_valid_q;
    assign cmd_c        = rx_data[9:8];
    assign payload_c    = rx_data[7:0];
    assign payload_ok_c = ({1'b0, payload_c} < 9'(MEM_DEPTH));

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rx_valid_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_vld_q <= 1'b0;
            rd_ptr_vld_q <= 1'b0;
            lat_q        <= '0;
            hold_cnt_q   <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_valid_q   <= rx_valid;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_vld_q <= wr_ptr_vld_d;
            rd_ptr_vld_q <= rd_ptr_vld_d;
            lat_q        <= lat_d;
            hold_cnt_q   <= hold_cnt_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            busy_q       <= (state_d != IDLE);
            err_q        <= err_d;
        end
    end

    // Next-state logic; RAM strobes are set on the edge that enters an ISSUE state
    // so that ram_en is visible exactly during that state.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_vld_d = wr_ptr_vld_q;
        rd_ptr_vld_d = rd_ptr_vld_q;
        lat_d        = lat_q;
        hold_cnt_d   = hold_cnt_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        ram_en_d     = 1'b0;
        ram_we_d     = ram_we_q;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        err_d        = 1'b0;
        take_cmd_c   = 1'b0;

        case (state_q)
            IDLE: begin
                take_cmd_c = accept_c;
            end
            WR_ISSUE: begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                state_d  = IDLE;
                err_d    = accept_c;
            end
            RD_ISSUE: begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                lat_d    = LAT_W'(RD_LATENCY);
                state_d  = RD_WAIT;
                err_d    = accept_c;
            end
            RD_WAIT: begin
                err_d = accept_c;
                if (lat_q == LAT_W'(1)) begin
                    tx_data_d  = ram_rdata;
                    tx_valid_d = 1'b1;
                    hold_cnt_d = '0;
                    state_d    = TX_WAIT;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            TX_WAIT: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (accept_c || tx_ack || (hold_cnt_q == HOLD_W'(TX_HOLD - 1))) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
                take_cmd_c = accept_c;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new command in IDLE or TX_WAIT overrides the state chosen above.
        if (take_cmd_c) begin
            case (cmd_c)
                2'b00: begin
                    if (payload_ok_c) begin
                        wr_ptr_d     = payload_c[ADDR_SIZE-1:0];
                        wr_ptr_vld_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                2'b10: begin
                    if (payload_ok_c) begin
                        rd_ptr_d     = payload_c[ADDR_SIZE-1:0];
                        rd_ptr_vld_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (wr_ptr_vld_q) begin
                        state_d     = WR_ISSUE;
                        ram_en_d    = 1'b1;
                        ram_we_d    = 1'b1;
                        ram_addr_d  = wr_ptr_q;
                        ram_wdata_d = payload_c;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    if (rd_ptr_vld_q) begin
                        state_d    = RD_ISSUE;
                        ram_en_d   = 1'b1;
                        ram_we_d   = 1'b0;
                        ram_addr_d = rd_ptr_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// tb_spi_ram_ctrl: directed checks of spi_ram_ctrl command handling.
// Instance a uses MEM_DEPTH=256, instance b MEM_DEPTH=128; both share stimulus.
module tb_spi_ram_ctrl;

    logic       clk;
    logic       rst;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic       tx_ack;
    logic [7:0] ram_rdata;
    logic [7:0] rd_s1;

    logic [7:0] a_tx_data, b_tx_data;
    logic       a_tx_valid, b_tx_valid;
    logic       a_ram_en, b_ram_en;
    logic       a_ram_we, b_ram_we;
    logic [7:0] a_ram_addr, b_ram_addr;
    logic [7:0] a_ram_wdata, b_ram_wdata;
    logic       a_busy, b_busy;
    logic       a_err, b_err;

    int n_chk = 0;
    int n_bad = 0;
    int n;
    int n_err;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8), .RD_LATENCY(2), .TX_HOLD(16)) u_dut_a (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(a_tx_data), .tx_valid(a_tx_valid), .tx_ack(tx_ack),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_wdata(a_ram_wdata), .ram_rdata(ram_rdata), .busy(a_busy), .err(a_err)
    );

    spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(8), .RD_LATENCY(2), .TX_HOLD(16)) u_dut_b (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(b_tx_data), .tx_valid(b_tx_valid), .tx_ack(tx_ack),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_wdata(b_ram_wdata), .ram_rdata(ram_rdata), .busy(b_busy), .err(b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed RAM contents for the addresses the reads touch.
    function automatic logic [7:0] rom(input logic [7:0] a);
        case (a)
            8'h10:   return 8'h3C;
            8'h11:   return 8'h5A;
            8'hFF:   return 8'h77;
            8'h00:   return 8'h11;
            default: return 8'hE5;
        endcase
    endfunction

    // Two-cycle read pipeline: data valid two cycles after the strobe cycle.
    always @(posedge clk) begin
        rd_s1     <= rom(a_ram_addr);
        ram_rdata <= rd_s1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // One low-sampled edge, then a one-cycle rx_valid pulse; returns in cycle T+1.
    task automatic send(input logic [9:0] w);
        tick;
        rx_data  = w;
        rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input string tag);
        int k;
        k = 0;
        while (!a_tx_valid && k < 20) begin
            tick;
            k++;
        end
        chk(tag, 32'(a_tx_valid), 32'd1);
    endtask

    task automatic ack;
        tx_ack = 1'b1;
        tick;
        tx_ack = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;
        tx_ack   = 1'b0;
        repeat (2) tick;
        chk("reset_outputs", 32'({a_tx_data, a_tx_valid, a_ram_en, a_ram_we, a_ram_addr,
                                  a_ram_wdata, a_busy, a_err}), 32'd0);
        rst = 1'b0;

        // Data commands with no valid pointer
        send(10'h1AA);
        chk("wr_no_ptr_err", 32'({a_err, a_ram_en}), 32'b10);
        tick;
        chk("err_one_cycle", 32'(a_err), 32'd0);
        send(10'h355);
        chk("rd_no_ptr_err", 32'({a_err, a_ram_en}), 32'b10);

        // Write path
        send(10'h005);
        chk("wr_addr_ok", 32'({a_err, a_busy, a_ram_en}), 32'd0);
        send(10'h1AA);
        chk("wr1_strobe", 32'({a_ram_en, a_ram_we, a_ram_addr, a_ram_wdata, a_busy}),
            32'({1'b1, 1'b1, 8'h05, 8'hAA, 1'b1}));
        tick;
        chk("wr1_hold", 32'({a_ram_en, a_ram_addr, a_ram_wdata, a_busy}),
            32'({1'b0, 8'h05, 8'hAA, 1'b0}));
        send(10'h1BB);
        chk("wr2_incr", 32'({a_ram_en, a_ram_we, a_ram_addr, a_ram_wdata}),
            32'({1'b1, 1'b1, 8'h06, 8'hBB}));

        // Address beyond a 128-word RAM
        send(10'h0C8);
        chk("range_b_err", 32'(b_err), 32'd1);
        chk("range_a_ok", 32'(a_err), 32'd0);
        send(10'h1CC);
        chk("range_b_ptr_kept", 32'({b_ram_en, b_ram_addr}), 32'({1'b1, 8'h07}));
        chk("range_a_ptr_set", 32'({a_ram_en, a_ram_addr}), 32'({1'b1, 8'hC8}));

        // rx_valid held high: one write only
        send(10'h020);
        tick;
        rx_data  = 10'h1AA;
        rx_valid = 1'b1;
        n = 0;
        n_err = 0;
        repeat (5) begin
            tick;
            n += int'(a_ram_en);
            n_err += int'(a_err);
        end
        rx_valid = 1'b0;
        repeat (3) begin
            tick;
            n += int'(a_ram_en);
            n_err += int'(a_err);
        end
        chk("level_one_write", 32'(n), 32'd1);
        chk("level_no_err", 32'(n_err), 32'd0);

        // Read path, latency 2
        send(10'h210);
        send(10'h300);
        chk("rd_strobe", 32'({a_ram_en, a_ram_we, a_ram_addr}), 32'({1'b1, 1'b0, 8'h10}));
        tick;
        tick;
        chk("rd_t3_not_valid", 32'(a_tx_valid), 32'd0);
        tick;
        chk("rd_t4_valid", 32'({a_tx_valid, a_tx_data, a_busy}), 32'({1'b1, 8'h3C, 1'b1}));
        ack;
        chk("rd_after_ack", 32'({a_tx_valid, a_busy}), 32'd0);

        // Edge while busy is dropped with err, pointer untouched
        send(10'h300);
        send(10'h2AA);
        chk("busy_edge_err", 32'(a_err), 32'd1);
        wait_tx("busy_rd_valid");
        chk("busy_rd_data", 32'(a_tx_data), 32'h5A);
        ack;
        send(10'h300);
        chk("drop_ptr_kept", 32'({a_ram_en, a_ram_addr}), 32'({1'b1, 8'h12}));
        wait_tx("drop_rd_valid");
        ack;

        // Wrap FF -> 00 with the second read streamed from TX_WAIT
        send(10'h2FF);
        send(10'h300);
        chk("wrap_ff", 32'({a_ram_en, a_ram_addr}), 32'({1'b1, 8'hFF}));
        wait_tx("wrap_ff_valid");
        chk("wrap_ff_data", 32'(a_tx_data), 32'h77);
        send(10'h300);
        chk("stream_00", 32'({a_ram_en, a_ram_we, a_ram_addr, a_err, a_tx_valid}),
            32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
        wait_tx("wrap_00_valid");
        chk("wrap_00_data", 32'(a_tx_data), 32'h11);

        // No ack: tx_valid lasts TX_HOLD cycles
        n = 0;
        while (a_tx_valid && n < 40) begin
            n++;
            tick;
        end
        chk("hold_cycles", 32'(n), 32'd16);
        chk("hold_idle", 32'(a_busy), 32'd0);

        // Reset during RD_WAIT
        send(10'h300);
        tick;
        chk("mid_rd_busy", 32'(a_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", 32'({a_tx_data, a_tx_valid, a_ram_en, a_ram_we, a_ram_addr,
                                      a_ram_wdata, a_busy, a_err}), 32'd0);
        tick;
        rst = 1'b0;
        n = 0;
        repeat (8) begin
            tick;
            n += int'(a_tx_valid);
        end
        chk("rst_no_tx", 32'(n), 32'd0);
        send(10'h300);
        chk("rst_rd_ptr_invalid", 32'({a_err, a_ram_en}), 32'b10);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
